unit_alu_pipe: RTL and testbench
================================

Name: unit_alu_pipe

Overview:
- Parametrised, pipelined successor of the 28-bit combinational add/sub ALU used on the FPU mantissa datapath.
- Adds a magnitude-subtract mode for mantissa alignment and a zero flag.
- Carries a user tag alongside each operation.
- Has a valid/ready handshake and STAGES-deep buffering, so it sits between the exponent-align stage and the normaliser with full backpressure support.

Parameters:
- WIDTH, 28, operand/result width in bits (>=2).
- STAGES, 2, pipeline depth = latency in cycles (>=1); each stage holds one operation.
- TAG_W, 4, width of the pass-through tag (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation present on the input bus.
- in_ready  output  1  stage 1 can accept this cycle.
- augend  input  WIDTH  operand A.
- addend  input  WIDTH  operand B.
- mode  input  2  00=ADD, 01=SUB (A-B), 10=SUBMAG (|A-B|), 11=PASS (A).
- in_tag  input  TAG_W  user tag, returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  result.
- c_alu  output  1  carry / no-borrow / ordering flag, per mode.
- zero  output  1  result == 0.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
Reset (rst=1 at an edge):
- Clears every stage valid bit and zeroes all stage data, so out_valid=0, result=0, c_alu=0, zero=0, out_tag=0.
- in_ready=1 on the first cycle after reset.
- Operations in flight are discarded, with no partial output.
- Reset has priority over a simultaneous handshake.

Arithmetic (evaluated combinationally ahead of stage 1, on a WIDTH+1 extended sum):
- ADD: {0,A}+{0,B}; result = low WIDTH bits; c_alu = bit WIDTH (carry-out).
- SUB: {0,A}+{0,~B}+1; result = low WIDTH bits (two's complement, wraps); c_alu = bit WIDTH (1 = no borrow, i.e. A>=B unsigned).
- SUBMAG: if A>=B, result=A-B and c_alu=1; else result=B-A and c_alu=0. A==B gives result=0, c_alu=1.
- PASS: result=A, c_alu=0.
- zero = (result == 0) for every mode, computed with the result and registered.

Pipeline:
- Stage k holds {valid, result, c_alu, zero, tag}; stage STAGES drives the outputs directly from registers.
- Stage k advances when it is empty or stage k+1 is advancing; the last stage advances when out_ready=1 or it is empty.
- in_ready = stage 1 advance condition, computed combinationally from downstream state.
- Bubbles collapse: an empty stage accepts even while later stages are stalled. Capacity is STAGES operations.
- Input handshake: in_valid && in_ready on an edge.
- Output handshake: out_valid && out_ready on an edge.
- With no stalls, an op accepted on edge N appears with out_valid=1 after edge N+STAGES-1 and is consumed on edge N+STAGES; throughput is one op per cycle.
- Outputs are held stable while out_valid=1 && out_ready=0.
- A full pipeline with out_ready=1 accepts a new op in the same cycle (simultaneous push and pop).
- Results leave strictly in acceptance order.
- in_valid with in_ready=0 is ignored; the source must hold its request.

Constraints:
- No combinational path from augend/addend to any output.
- The only combinational input-to-output path is out_ready -> in_ready.

Test Plan:
1. WIDTH=28, STAGES=2, out_ready=1.
   - ADD A=0FFFFFF, B=0000001 -> result=1000000, c_alu=0, zero=0.
   - ADD A=FFFFFFF, B=0000001 -> result=0000000, c_alu=1, zero=1.
   - Each appears 2 cycles after acceptance.
2. SUB and SUBMAG.
   - SUB A=0000005, B=0000007 -> result=FFFFFFE, c_alu=0.
   - SUBMAG same operands -> result=0000002, c_alu=0.
   - SUBMAG A=B=1234567 -> result=0, c_alu=1, zero=1.
   - PASS A=ABCDEF0 -> result=ABCDEF0, c_alu=0.
3. Backpressure.
   - Hold out_ready=0 and offer 4 back-to-back ops with tags 1..4 -> exactly 2 accepted; in_ready=0 thereafter; outputs stable.
   - Release out_ready -> tags emerge 1,2,3,4 with no loss or duplication, one per cycle.
4. Throughput.
   - 20 random back-to-back ops, out_ready=1 -> first out_valid 2 cycles after the first accept, then one result per cycle.
   - All results match the golden model.
5. Reset mid-operation.
   - Pulse rst with 2 ops in flight -> next cycle out_valid=0, result=0, in_ready=1.
   - The first op after reset returns correctly with its own tag.
6. Parameter sweep WIDTH=8, STAGES=1.
   - ADD FF+01 -> result=00, c_alu=1, zero=1, one cycle latency.
   - Random 200 ops with random out_ready -> zero mismatches against the golden model.

Source files
------------

// File: rtl/unit_alu_pipe.sv
// Pipelined add/sub/magnitude-subtract ALU for the mantissa datapath.
// The ALU feeds STAGES elastic stages with valid/ready flow control and a carried tag.
module unit_alu_pipe #(
    parameter int WIDTH  = 28,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] augend,
    input  logic [WIDTH-1:0] addend,
    input  logic [1:0]       mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_alu,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        MODE_ADD    = 2'b00,
        MODE_SUB    = 2'b01,
        MODE_SUBMAG = 2'b10,
        MODE_PASS   = 2'b11
    } mode_e;

    logic [WIDTH:0]   sumAdd;
    logic [WIDTH:0]   sumSub;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             zero_d;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] zero_q;
    logic [WIDTH-1:0]  result_q [STAGES];
    logic [TAG_W-1:0]  tag_q    [STAGES];
    logic [STAGES-1:0] advance;

    // Bit WIDTH of the subtract sum is the no-borrow flag, so it also selects the SUBMAG direction.
    always_comb begin
        sumAdd   = {1'b0, augend} + {1'b0, addend};
        sumSub   = {1'b0, augend} + {1'b0, ~addend} + {{WIDTH{1'b0}}, 1'b1};
        result_d = '0;
        carry_d  = 1'b0;
        case (mode_e'(mode))
            MODE_ADD: begin
                result_d = sumAdd[WIDTH-1:0];
                carry_d  = sumAdd[WIDTH];
            end
            MODE_SUB: begin
                result_d = sumSub[WIDTH-1:0];
                carry_d  = sumSub[WIDTH];
            end
            MODE_SUBMAG: begin
                carry_d  = sumSub[WIDTH];
                result_d = sumSub[WIDTH] ? sumSub[WIDTH-1:0]
                                         : (~sumSub[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1});
            end
            default: begin
                result_d = augend;
                carry_d  = 1'b0;
            end
        endcase
        zero_d = (result_d == '0);
    end

    // A stage may move whenever any stage at or beyond it is empty, or the output is draining.
    always_comb begin
        logic allFull;
        allFull = 1'b1;
        advance = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            allFull    = allFull & valid_q[k];
            advance[k] = out_ready | ~allFull;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                result_q[k] <= '0;
                tag_q[k]    <= '0;
            end
        end else begin
            if (advance[0]) begin
                valid_q[0]  <= in_valid;
                result_q[0] <= result_d;
                carry_q[0]  <= carry_d;
                zero_q[0]   <= zero_d;
                tag_q[0]    <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (advance[k]) begin
                    valid_q[k]  <= valid_q[k-1];
                    result_q[k] <= result_q[k-1];
                    carry_q[k]  <= carry_q[k-1];
                    zero_q[k]   <= zero_q[k-1];
                    tag_q[k]    <= tag_q[k-1];
                end
            end
        end
    end

    assign in_ready  = advance[0];
    assign out_valid = valid_q[STAGES-1];
    assign result    = result_q[STAGES-1];
    assign c_alu     = carry_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_unit_alu_pipe.sv
// Bench for unit_alu_pipe: a 28-bit/2-stage and an 8-bit/1-stage instance checked
// against directed vectors and a queue-based arithmetic reference model.
module tb_unit_alu_pipe;

    typedef struct {
        logic [27:0] res;
        logic        c;
        logic        z;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [27:0] a;
        logic [27:0] b;
        logic [27:0] res;
        logic        c;
        logic        z;
    } vec_t;

    logic clk;
    logic rst;

    logic        iv28, irdy28, ov28, ordy28, c28, z28;
    logic [27:0] a28, b28, res28;
    logic [1:0]  m28;
    logic [3:0]  tag28, otag28;

    logic        iv8, irdy8, ov8, ordy8, c8, z8;
    logic [7:0]  a8, b8, res8;
    logic [1:0]  m8;
    logic [3:0]  tag8, otag8;

    int   vectors;
    int   miscompares;
    exp_t q28[$];
    exp_t q8[$];
    vec_t vecs[9];

    unit_alu_pipe #(.WIDTH(28), .STAGES(2), .TAG_W(4)) dut28 (
        .clk(clk), .rst(rst), .in_valid(iv28), .in_ready(irdy28),
        .augend(a28), .addend(b28), .mode(m28), .in_tag(tag28),
        .out_valid(ov28), .out_ready(ordy28), .result(res28),
        .c_alu(c28), .zero(z28), .out_tag(otag28)
    );

    unit_alu_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(irdy8),
        .augend(a8), .addend(b8), .mode(m8), .in_tag(tag8),
        .out_valid(ov8), .out_ready(ordy8), .result(res8),
        .c_alu(c8), .zero(z8), .out_tag(otag8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t refModel(int w, logic [1:0] m, longint a, longint b, logic [3:0] t);
        exp_t   e;
        longint mask;
        longint r;
        mask = (longint'(1) << w) - 1;
        e.c  = 1'b0;
        case (m)
            2'd0: begin
                r   = a + b;
                e.c = (r > mask);
                r   = r & mask;
            end
            2'd1: begin
                e.c = (a >= b);
                r   = (a - b) & mask;
            end
            2'd2: begin
                if (a >= b) begin
                    r   = a - b;
                    e.c = 1'b1;
                end else begin
                    r   = b - a;
                    e.c = 1'b0;
                end
            end
            default: r = a;
        endcase
        e.res = r[27:0];
        e.z   = (r == 0);
        e.tag = t;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic runScoreboards();
        exp_t e;
        if (rst) begin
            q28.delete();
            q8.delete();
        end else begin
            if (ov28 && ordy28) begin
                if (q28.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL sb28: unexpected result tag %h, expected none", otag28);
                end else begin
                    e = q28.pop_front();
                    checkOutput("sb28", {res28, c28, z28, otag28}, {e.res, e.c, e.z, e.tag});
                end
            end
            if (iv28 && irdy28)
                q28.push_back(refModel(28, m28, longint'(a28), longint'(b28), tag28));
            if (ov8 && ordy8) begin
                if (q8.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL sb8: unexpected result tag %h, expected none", otag8);
                end else begin
                    e = q8.pop_front();
                    checkOutput("sb8", {res8, c8, z8, otag8}, {e.res[7:0], e.c, e.z, e.tag});
                end
            end
            if (iv8 && irdy8)
                q8.push_back(refModel(8, m8, longint'(a8), longint'(b8), tag8));
        end
    endtask

    task automatic waitNeg();
        @(negedge clk);
        runScoreboards();
    endtask

    task automatic waitPos();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [27:0] a,
                                 input logic [27:0] b, input logic [3:0] t);
        iv28  = v;
        m28   = m;
        a28   = a;
        b28   = b;
        tag28 = t;
    endtask

    task automatic applyRandom(input logic [3:0] t);
        logic [27:0] a;
        logic [27:0] b;
        a = 28'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : 28'($urandom);
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), a, b, t);
    endtask

    initial begin
        int   accepted;
        logic acc;
        logic pend;
        logic [3:0]  tagN;
        logic [33:0] held;

        vectors     = 0;
        miscompares = 0;
        vecs[0] = '{2'd0, 28'h0FFFFFF, 28'h0000001, 28'h1000000, 1'b0, 1'b0};
        vecs[1] = '{2'd0, 28'hFFFFFFF, 28'h0000001, 28'h0000000, 1'b1, 1'b1};
        vecs[2] = '{2'd1, 28'h0000005, 28'h0000007, 28'hFFFFFFE, 1'b0, 1'b0};
        vecs[3] = '{2'd2, 28'h0000005, 28'h0000007, 28'h0000002, 1'b0, 1'b0};
        vecs[4] = '{2'd2, 28'h1234567, 28'h1234567, 28'h0000000, 1'b1, 1'b1};
        vecs[5] = '{2'd3, 28'hABCDEF0, 28'h0001234, 28'hABCDEF0, 1'b0, 1'b0};
        vecs[6] = '{2'd1, 28'h0000007, 28'h0000005, 28'h0000002, 1'b1, 1'b0};
        vecs[7] = '{2'd2, 28'h0000007, 28'h0000005, 28'h0000002, 1'b1, 1'b0};
        vecs[8] = '{2'd3, 28'h0000000, 28'hFFFFFFF, 28'h0000000, 1'b0, 1'b1};

        rst    = 1'b1;
        ordy28 = 1'b1;
        ordy8  = 1'b1;
        applyStimulus(1'b0, 2'd0, 28'h0, 28'h0, 4'h0);
        iv8 = 1'b0; m8 = 2'd0; a8 = 8'h0; b8 = 8'h0; tag8 = 4'h0;
        waitNeg(); waitPos();
        waitNeg(); waitPos();
        rst = 1'b0;

        waitNeg();
        checkOutput("reset out_valid", ov28, 1'b0);
        checkOutput("reset result", res28, 28'h0);
        checkOutput("reset c/z/tag", {c28, z28, otag28}, 6'h0);
        checkOutput("reset in_ready", irdy28, 1'b1);
        checkOutput("reset8 state", {ov8, res8, c8, z8, otag8, irdy8}, 16'h0001);
        waitPos();

        // Directed vectors, one at a time, checking two-cycle latency.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, 4'(i));
            waitNeg(); waitPos();
            applyStimulus(1'b0, 2'd0, 28'h0, 28'h0, 4'h0);
            waitNeg();
            checkOutput($sformatf("vec%0d early valid", i), ov28, 1'b0);
            waitPos();
            waitNeg();
            checkOutput($sformatf("vec%0d valid", i), ov28, 1'b1);
            checkOutput($sformatf("vec%0d result", i), {res28, c28, z28, otag28},
                        {vecs[i].res, vecs[i].c, vecs[i].z, 4'(i)});
            waitPos();
        end

        // Backpressure: only STAGES ops fit while the output is stalled.
        ordy28   = 1'b0;
        tagN     = 4'd1;
        accepted = 0;
        applyRandom(tagN);
        for (int k = 0; k < 4; k++) begin
            waitNeg();
            acc = irdy28;
            waitPos();
            if (acc) begin
                accepted++;
                tagN = tagN + 4'd1;
                applyRandom(tagN);
            end
        end
        checkOutput("bp accepted", 64'(accepted), 64'd2);
        waitNeg();
        checkOutput("bp in_ready", irdy28, 1'b0);
        checkOutput("bp head", {ov28, otag28}, 5'h11);
        held = {res28, c28, z28, otag28};
        waitPos();
        waitNeg();
        checkOutput("bp stable", {res28, c28, z28, otag28}, held);
        waitPos();
        ordy28 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitNeg();
            checkOutput($sformatf("bp drain%0d", k), {ov28, otag28}, {1'b1, 4'(k + 1)});
            waitPos();
            if (k == 0) applyRandom(4'd4);
            else applyStimulus(1'b0, 2'd0, 28'h0, 28'h0, 4'h0);
        end
        waitNeg();
        checkOutput("bp empty", ov28, 1'b0);
        waitPos();

        // Throughput: back-to-back ops, one result per cycle after the fill latency.
        for (int i = 0; i < 20; i++) begin
            applyRandom(4'(i));
            waitNeg();
            checkOutput($sformatf("tp%0d ready/valid", i), {irdy28, ov28}, {1'b1, (i >= 2)});
            waitPos();
        end
        applyStimulus(1'b0, 2'd0, 28'h0, 28'h0, 4'h0);
        waitNeg(); checkOutput("tp tail1", ov28, 1'b1); waitPos();
        waitNeg(); checkOutput("tp tail2", ov28, 1'b1); waitPos();
        waitNeg(); checkOutput("tp tail3", ov28, 1'b0); waitPos();

        // Reset with two ops in flight and a simultaneous input handshake.
        ordy28 = 1'b0;
        applyRandom(4'd5);
        waitNeg(); waitPos();
        applyRandom(4'd6);
        waitNeg(); waitPos();
        applyRandom(4'd7);
        rst = 1'b1;
        waitNeg(); waitPos();
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 28'h0, 28'h0, 4'h0);
        waitNeg();
        checkOutput("rst flush", {ov28, res28, otag28, irdy28}, {1'b0, 28'h0, 4'h0, 1'b1});
        waitPos();
        ordy28 = 1'b1;
        applyStimulus(1'b1, 2'd0, 28'h0000100, 28'h0000023, 4'hA);
        waitNeg(); waitPos();
        applyStimulus(1'b0, 2'd0, 28'h0, 28'h0, 4'h0);
        waitNeg(); checkOutput("post-rst early", ov28, 1'b0); waitPos();
        waitNeg();
        checkOutput("post-rst op", {ov28, res28, c28, z28, otag28}, {1'b1, 28'h0000123, 1'b0, 1'b0, 4'hA});
        waitPos();

        // 8-bit, single-stage instance.
        iv8 = 1'b1; m8 = 2'd0; a8 = 8'hFF; b8 = 8'h01; tag8 = 4'h3;
        waitNeg(); waitPos();
        iv8 = 1'b0;
        waitNeg();
        checkOutput("w8 add wrap", {ov8, res8, c8, z8, otag8}, {1'b1, 8'h00, 1'b1, 1'b1, 4'h3});
        waitPos();

        pend = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!pend) begin
                iv8  = ($urandom_range(0, 3) != 0);
                m8   = 2'($urandom_range(0, 3));
                a8   = 8'($urandom);
                b8   = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
                tag8 = 4'($urandom);
            end
            ordy8 = ($urandom_range(0, 2) != 0);
            waitNeg();
            acc = iv8 && irdy8;
            waitPos();
            pend = iv8 && !acc;
        end
        iv8   = 1'b0;
        ordy8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitNeg(); waitPos();
        end

        checkOutput("sb28 drained", 64'(q28.size()), 64'd0);
        checkOutput("sb8 drained", 64'(q8.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
